// File: rtl/pipe_alu_pkg.sv
// Shared types for the pipelined ALU.
//   alu_op_e    : 4-bit opcode encoding
//   alu_flags_t : status flags {n,z,c,v}
//   OP_W        : opcode width
package alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_SLL   = 4'd2,
        OP_SRL   = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_EQ    = 4'd7,
        OP_SRA   = 4'd8,
        OP_SLT   = 4'd9,
        OP_SLTU  = 4'd10,
        OP_MIN   = 4'd11,
        OP_MAX   = 4'd12,
        OP_PASSB = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } alu_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/pipe_alu_if.sv
// Command/result bus of pipe_alu.
//   command side : in_valid_i, in_ready_o, a_i, b_i, op_i, acc_sel_i
//   result side  : out_valid_o, out_ready_i, res_o, flags_o
// slave modport is the ALU, master modport the driver/consumer.
interface pipe_alu_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    alu_op_e          op_i;
    logic             acc_sel_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] res_o;
    alu_flags_t       flags_o;

    modport slave (
        input  in_valid_i, a_i, b_i, op_i, acc_sel_i, out_ready_i,
        output in_ready_o, out_valid_o, res_o, flags_o
    );

    modport master (
        output in_valid_i, a_i, b_i, op_i, acc_sel_i, out_ready_i,
        input  in_ready_o, out_valid_o, res_o, flags_o
    );
endinterface

// File: rtl/pipe_alu_core.sv
// Combinational ALU datapath.
//   a, b  : operands
//   op    : opcode
//   res   : result (modulo 2^WIDTH)
//   flags : {n,z,c,v}; c/v only meaningful for ADD, SUB and shifts
module alu_core
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] res,
    output alu_flags_t       flags
);

    logic [SHW-1:0] sh;
    logic [WIDTH:0] sum;
    logic           cflag;
    logic           vflag;
    logic           reserved;

    always_comb begin
        sh       = b[SHW-1:0];
        sum      = '0;
        res      = '0;
        cflag    = 1'b0;
        vflag    = 1'b0;
        reserved = 1'b0;
        case (op)
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b};
                res   = sum[WIDTH-1:0];
                cflag = sum[WIDTH];
                vflag = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // carry-out of a + ~b + 1 is the "no borrow" (a >= b) indication
                sum   = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                res   = sum[WIDTH-1:0];
                cflag = sum[WIDTH];
                vflag = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            // one guard bit beside the operand catches the last bit shifted out;
            // it stays 0 for a zero shift
            OP_SLL:   {cflag, res} = {1'b0, a} << sh;
            OP_SRL:   {res, cflag} = {a, 1'b0} >> sh;
            OP_SRA:   {res, cflag} = $signed({a, 1'b0}) >>> sh;
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_EQ:    res = WIDTH'(a == b);
            OP_SLT:   res = WIDTH'($signed(a) < $signed(b));
            OP_SLTU:  res = WIDTH'(a < b);
            OP_MIN:   res = ($signed(a) < $signed(b)) ? a : b;
            OP_MAX:   res = ($signed(a) < $signed(b)) ? b : a;
            OP_PASSB: res = b;
            default:  reserved = 1'b1;
        endcase

        flags.n = res[WIDTH-1];
        flags.z = (res == '0);
        flags.c = cflag;
        flags.v = vflag;
        // reserved opcodes report all-zero flags, including z
        if (reserved) begin
            flags = '0;
        end
    end

endmodule

// File: rtl/pipe_alu.sv
// Two-stage pipelined ALU with valid/ready handshakes and accumulator chaining.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : pipe_alu_if.slave (command in, result out)
// S1 holds the accepted operands, S2 holds the computed result/flags that
// drive the outputs directly.
module pipe_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    pipe_alu_if.slave    bus
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    alu_op_e          s1_op;
    logic             s2_valid;
    logic [WIDTH-1:0] s2_res;
    alu_flags_t       s2_flags;
    logic [WIDTH-1:0] acc;

    logic             s2_load;
    logic             s1_load;
    logic             interlock;
    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] core_res;
    alu_flags_t       core_flags;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a     (s1_a),
        .b     (s1_b),
        .op    (s1_op),
        .res   (core_res),
        .flags (core_flags)
    );

    always_comb begin
        s2_load   = !s2_valid || bus.out_ready_i;
        s1_load   = !s1_valid || s2_load;
        // a chained command must wait for every older result to reach acc
        interlock = bus.in_valid_i && bus.acc_sel_i && (s1_valid || s2_valid);
        in_ready  = reset_n && s1_load && !interlock;
        accept    = bus.in_valid_i && in_ready;
    end

    always_comb begin
        bus.in_ready_o  = in_ready;
        bus.out_valid_o = s2_valid;
        bus.res_o       = s2_res;
        bus.flags_o     = s2_flags;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
        end else if (s1_load) begin
            s1_valid <= accept;
            if (accept) begin
                s1_a  <= bus.acc_sel_i ? acc : bus.a_i;
                s1_b  <= bus.b_i;
                s1_op <= bus.op_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_flags <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_res   <= core_res;
                s2_flags <= core_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (s2_valid && bus.out_ready_i) begin
            acc <= s2_res;
        end
    end

endmodule
